// File: rtl/nand_prog_engine.sv
// nand_prog_engine: sequences a NAND page-program or block-erase on the shared
// flash pins and pulls program data from the 128x8 buffer memory.
// Optional feature macro: NAND_STATUS_CHK_EN adds a status read (70h) after
// the ready wait, and err reports status bit0. Without it, err stays 0 and
// F_REN stays 1.
module nand_prog_engine #(
  parameter int unsigned TWB_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [17:0] f_addr,
  input  logic [6:0]  m_addr,
  input  logic [6:0]  len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        M_RW,
  output logic [6:0]  M_A,
  input  logic [7:0]  M_D,
  output logic [7:0]  F_OUT,
  output logic        F_EN,
  input  logic [7:0]  F_IN,
  output logic        F_CLE,
  output logic        F_ALE,
  output logic        F_WEN,
  output logic        F_REN,
  input  logic        F_RB
);

  localparam int unsigned TCNT_W = 16;

  localparam logic [7:0] CMD_PTR_LO  = 8'h00;
  localparam logic [7:0] CMD_PTR_HI  = 8'h01;
  localparam logic [7:0] CMD_PROG    = 8'h80;
  localparam logic [7:0] CMD_PROG_GO = 8'h10;
  localparam logic [7:0] CMD_ERASE   = 8'h60;
  localparam logic [7:0] CMD_ERASE_GO = 8'hD0;
`ifdef NAND_STATUS_CHK_EN
  localparam logic [7:0] CMD_STATUS  = 8'h70;
`endif

  typedef enum logic [3:0] {
    IDLE,
    PTR,
    CMD1,
    ADDR,
    FETCH,
    DATA,
    CMD2,
    TWB,
    WAIT_RB,
`ifdef NAND_STATUS_CHK_EN
    STAT_CMD,
    STAT_RD,
`endif
    DONE
  } state_t;

  state_t              state;
  logic                phase;   // 0: WEN/REN low half, 1: rising-strobe half
  logic                op_r;
  logic [7:0]          col_r;
  logic [8:0]          row_r;   // {f_addr[17], f_addr[16:9]}
  logic [6:0]          ma_r;
  logic [6:0]          cnt;     // data bytes remaining after the current one
  logic [1:0]          aidx;
  logic [TCNT_W-1:0]   tcnt;

  // Only read requests are ever issued to the buffer.
  assign M_RW = 1'b1;

  // Keeps the full flash input bus referenced in every build.
  logic unused_fin;
  assign unused_fin = ^F_IN;

  // Address cycle byte: 0 = column, 1 = row low, 2 = row high.
  function automatic logic [7:0] addr_byte(input logic [1:0] idx,
                                           input logic [7:0] col,
                                           input logic [8:0] row);
    case (idx)
      2'd0:    addr_byte = col;
      2'd1:    addr_byte = row[7:0];
      default: addr_byte = {7'd0, row[8]};
    endcase
  endfunction

  // Sequencer: state, counters and all registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 1'b0;
      op_r  <= 1'b0;
      col_r <= 8'h00;
      row_r <= 9'h000;
      ma_r  <= 7'h00;
      cnt   <= 7'h00;
      aidx  <= 2'd0;
      tcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      M_A   <= 7'h00;
      F_OUT <= 8'h00;
      F_EN  <= 1'b0;
      F_CLE <= 1'b0;
      F_ALE <= 1'b0;
      F_WEN <= 1'b1;
      F_REN <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            col_r <= f_addr[7:0];
            row_r <= {f_addr[17], f_addr[16:9]};
            ma_r  <= m_addr;
            cnt   <= len;
            err   <= 1'b0;
            busy  <= 1'b1;
            phase <= 1'b0;
            F_EN  <= 1'b1;
            F_CLE <= 1'b1;
            F_WEN <= 1'b0;
            if (op) begin
              state <= CMD1;
              F_OUT <= CMD_ERASE;
            end else begin
              state <= PTR;
              F_OUT <= f_addr[8] ? CMD_PTR_HI : CMD_PTR_LO;
            end
          end
        end

        PTR: begin
          if (!phase) begin
            F_WEN <= 1'b1;
            phase <= 1'b1;
          end else begin
            state <= CMD1;
            phase <= 1'b0;
            F_WEN <= 1'b0;
            F_OUT <= CMD_PROG;
          end
        end

        CMD1: begin
          if (!phase) begin
            F_WEN <= 1'b1;
            phase <= 1'b1;
          end else begin
            state <= ADDR;
            phase <= 1'b0;
            aidx  <= op_r ? 2'd1 : 2'd0;
            F_CLE <= 1'b0;
            F_ALE <= 1'b1;
            F_WEN <= 1'b0;
            F_OUT <= addr_byte(op_r ? 2'd1 : 2'd0, col_r, row_r);
          end
        end

        ADDR: begin
          if (!phase) begin
            F_WEN <= 1'b1;
            phase <= 1'b1;
            // Present the first buffer address a cycle early so M_D is ready in FETCH.
            if (aidx == 2'd2 && !op_r) M_A <= ma_r;
          end else begin
            phase <= 1'b0;
            if (aidx == 2'd2) begin
              F_ALE <= 1'b0;
              if (op_r) begin
                state <= CMD2;
                F_CLE <= 1'b1;
                F_WEN <= 1'b0;
                F_OUT <= CMD_ERASE_GO;
              end else begin
                state <= FETCH;
              end
            end else begin
              aidx  <= aidx + 2'd1;
              F_WEN <= 1'b0;
              F_OUT <= addr_byte(aidx + 2'd1, col_r, row_r);
            end
          end
        end

        FETCH: begin
          state <= DATA;
          phase <= 1'b0;
          F_OUT <= M_D;
          F_WEN <= 1'b0;
        end

        DATA: begin
          if (!phase) begin
            F_WEN <= 1'b1;
            phase <= 1'b1;
            if (cnt != 7'd0) M_A <= M_A + 7'd1;
          end else begin
            phase <= 1'b0;
            if (cnt == 7'd0) begin
              state <= CMD2;
              F_CLE <= 1'b1;
              F_WEN <= 1'b0;
              F_OUT <= CMD_PROG_GO;
            end else begin
              cnt   <= cnt - 7'd1;
              state <= FETCH;
            end
          end
        end

        CMD2: begin
          if (!phase) begin
            F_WEN <= 1'b1;
            phase <= 1'b1;
          end else begin
            state <= TWB;
            phase <= 1'b0;
            tcnt  <= '0;
            F_CLE <= 1'b0;
            F_EN  <= 1'b0;
          end
        end

        TWB: begin
          if (tcnt == TCNT_W'(TWB_CYC - 1)) state <= WAIT_RB;
          else                               tcnt  <= tcnt + TCNT_W'(1);
        end

        WAIT_RB: begin
          if (F_RB) begin
`ifdef NAND_STATUS_CHK_EN
            state <= STAT_CMD;
            phase <= 1'b0;
            F_EN  <= 1'b1;
            F_CLE <= 1'b1;
            F_WEN <= 1'b0;
            F_OUT <= CMD_STATUS;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end
        end

`ifdef NAND_STATUS_CHK_EN
        STAT_CMD: begin
          if (!phase) begin
            F_WEN <= 1'b1;
            phase <= 1'b1;
          end else begin
            state <= STAT_RD;
            phase <= 1'b0;
            F_CLE <= 1'b0;
            F_EN  <= 1'b0;
            F_REN <= 1'b0;
          end
        end

        STAT_RD: begin
          if (!phase) begin
            // Status byte is taken on the edge where REN rises.
            F_REN <= 1'b1;
            err   <= F_IN[0];
            phase <= 1'b1;
          end else begin
            state <= DONE;
            phase <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
